// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-N stream demultiplexer.
// Mode encoding and the select-width helper.
package demux_pkg;

  typedef enum logic {
    MODE_ADDR = 1'b0,
    MODE_RR   = 1'b1
  } mode_e;

  // Bits needed to index n items, never less than 1.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output register for a single demux channel.
// Ports: clk_i/rst_i, load_i+data_i write, valid_o/data_o/ready_i
// handshake, free_o = slot can take a beat this cycle.
module demux_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              free_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Free when empty or draining this cycle (pass-through refill).
  assign free_o  = ~valid_q | ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && ready_i) valid_d = 1'b0;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/demux_1_n_stream.sv
// Registered 1-to-N stream demux, addressed or round-robin steering.
// Ports: i_a/i_valid/o_ready in, o_code/o_valid/i_ready per channel,
// o_rr_ptr pointer, o_err/o_drop_cnt report dropped out-of-range beats.
module demux_1_n_stream
  import demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_CH   = 8,
  parameter int SEL_W  = clog2_min1(N_CH),
  parameter int CNT_W  = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_mode,
  input  logic [SEL_W-1:0]       i_sel_code,
  input  logic [DATA_W-1:0]      i_a,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [N_CH*DATA_W-1:0] o_code,
  output logic [N_CH-1:0]        o_valid,
  input  logic [N_CH-1:0]        i_ready,
  output logic [SEL_W-1:0]       o_rr_ptr,
  output logic                   o_err,
  output logic [CNT_W-1:0]       o_drop_cnt
);

  localparam logic [SEL_W:0]   NCH_L = (SEL_W+1)'(N_CH);
  localparam logic [SEL_W-1:0] LAST  = SEL_W'(N_CH - 1);

  logic [SEL_W-1:0] tgt;
  logic             in_range, tgt_free, accept, drop;
  logic [N_CH-1:0]  slot_free, load;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tgt      = (mode_e'(i_mode) == MODE_RR) ? ptr_q : i_sel_code;
    in_range = {1'b0, tgt} < NCH_L;
    tgt_free = 1'b0;
    for (int k = 0; k < N_CH; k++)
      if (tgt == SEL_W'(k)) tgt_free = slot_free[k];
    // Out-of-range beats are always taken so they can be discarded.
    o_ready  = ~i_rst & (~in_range | tgt_free);
    accept   = i_valid & o_ready;
    drop     = accept & ~in_range;
    load     = '0;
    for (int k = 0; k < N_CH; k++)
      load[k] = accept & in_range & (tgt == SEL_W'(k));
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept && mode_e'(i_mode) == MODE_RR)
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
    err_d = drop;
    cnt_d = cnt_q;
    if (drop && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_rr_ptr   = ptr_q;
  assign o_err      = err_q;
  assign o_drop_cnt = cnt_q;

  for (genvar k = 0; k < N_CH; k++) begin : g_slot
    demux_slot #(
      .DATA_W(DATA_W)
    ) u_slot (
      .clk_i  (i_clk),
      .rst_i  (i_rst),
      .load_i (load[k]),
      .data_i (i_a),
      .ready_i(i_ready[k]),
      .valid_o(o_valid[k]),
      .data_o (o_code[k*DATA_W +: DATA_W]),
      .free_o (slot_free[k])
    );
  end

endmodule

// File: tb/tb_demux_1_n_stream.sv
// Self-checking bench for demux_1_n_stream (N_CH=8 and N_CH=5).
// Per-channel scoreboard queues checked on every output handshake.
module tb_demux_1_n_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [2:0]  sel;
  logic [7:0]  a;
  logic        valid;
  logic        ready_o;
  logic [63:0] code;
  logic [7:0]  ov;
  logic [7:0]  rdy;
  logic [2:0]  ptr;
  logic        err;
  logic [7:0]  cnt;

  logic        mode5;
  logic [2:0]  sel5;
  logic [7:0]  a5;
  logic        valid5;
  logic        ready5_o;
  logic [39:0] code5;
  logic [4:0]  ov5;
  logic [4:0]  rdy5;
  logic [2:0]  ptr5;
  logic        err5;
  logic [7:0]  cnt5;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q [8][$];
  logic [7:0] mon_e;

  always #5 clk = ~clk;

  demux_1_n_stream dut (
    .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_sel_code(sel),
    .i_a(a), .i_valid(valid), .o_ready(ready_o), .o_code(code),
    .o_valid(ov), .i_ready(rdy), .o_rr_ptr(ptr), .o_err(err),
    .o_drop_cnt(cnt)
  );

  demux_1_n_stream #(.N_CH(5)) dut5 (
    .i_clk(clk), .i_rst(rst), .i_mode(mode5), .i_sel_code(sel5),
    .i_a(a5), .i_valid(valid5), .o_ready(ready5_o), .o_code(code5),
    .o_valid(ov5), .i_ready(rdy5), .o_rr_ptr(ptr5), .o_err(err5),
    .o_drop_cnt(cnt5)
  );

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 8; k++) begin
        if (ov[k] && rdy[k]) begin
          checks++;
          if (exp_q[k].size() == 0) begin
            failures++;
            $display("FAIL sb_ch%0d unexpected beat got=%h", k, code[k*8 +: 8]);
          end else begin
            mon_e = exp_q[k].pop_front();
            if (code[k*8 +: 8] !== mon_e) begin
              failures++;
              $display("FAIL sb_ch%0d got=%h exp=%h", k, code[k*8 +: 8], mon_e);
            end
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic m, input logic [2:0] s, input logic [7:0] d);
    mode = m; sel = s; a = d; valid = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; valid = 1'b0; mode = 1'b0; sel = '0; a = '0; rdy = '1;
    mode5 = 1'b0; sel5 = '0; a5 = '0; valid5 = 1'b0; rdy5 = '1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ready_o !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", ready_o); end
    checks++;
    if (ov !== 8'h00 || code !== 64'h0) begin
      failures++; $display("FAIL rst_outputs got=%h/%h exp=0", ov, code);
    end
    checks++;
    if (ptr !== 3'd0 || cnt !== 8'd0 || err !== 1'b0) begin
      failures++; $display("FAIL rst_state got=%0d/%0d/%b exp=0", ptr, cnt, err);
    end
    rst = 1'b0;
    tick();
    rdy = 8'hDB;
    drive(1'b0, 3'd2, 8'h22); exp_q[2].push_back(8'h22); tick();
    drive(1'b0, 3'd5, 8'h55); exp_q[5].push_back(8'h55); tick();
    drive(1'b0, 3'd3, 8'h33);
    checks++;
    if (ov !== 8'h24) begin failures++; $display("FAIL pre_rst_full got=%h exp=24", ov); end
    rst = 1'b1;
    #1;
    checks++;
    if (ov !== 8'h00 || ready_o !== 1'b0 || ptr !== 3'd0 || cnt !== 8'd0) begin
      failures++;
      $display("FAIL mid_rst got=%h/%b/%0d/%0d exp=00/0/0/0", ov, ready_o, ptr, cnt);
    end
    exp_q[2].delete();
    exp_q[5].delete();
    tick();
    checks++;
    if (ov !== 8'h00) begin failures++; $display("FAIL rst_no_load got=%h exp=00", ov); end
    valid = 1'b0;
    rst = 1'b0;
    rdy = '1;
    tick();
  endtask

  task automatic test_addr;
    rdy = '1;
    for (int s = 0; s < 8; s++) begin
      drive(1'b0, 3'(s), 8'(16 + s));
      @(negedge clk);
      checks++;
      if (ready_o !== 1'b1) begin failures++; $display("FAIL addr_ready%0d got=%b exp=1", s, ready_o); end
      exp_q[s].push_back(8'(16 + s));
      tick();
      checks++;
      if (ov !== 8'(1 << s) || code[s*8 +: 8] !== 8'(16 + s)) begin
        failures++;
        $display("FAIL addr_out%0d got=%h/%h exp=%h/%h", s, ov, code[s*8 +: 8], 8'(1 << s), 8'(16 + s));
      end
    end
    valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure;
    rdy = 8'hF7;
    drive(1'b0, 3'd3, 8'hA5);
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b1) begin failures++; $display("FAIL bp_first got=%b exp=1", ready_o); end
    exp_q[3].push_back(8'hA5);
    tick();
    drive(1'b0, 3'd3, 8'h5A);
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b0) begin failures++; $display("FAIL bp_stall got=%b exp=0", ready_o); end
    tick();
    checks++;
    if (ov[3] !== 1'b1 || code[31:24] !== 8'hA5) begin
      failures++; $display("FAIL bp_hold got=%b/%h exp=1/a5", ov[3], code[31:24]);
    end
    rdy = '1;
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b1) begin failures++; $display("FAIL bp_pass got=%b exp=1", ready_o); end
    exp_q[3].push_back(8'h5A);
    tick();
    checks++;
    if (ov !== 8'h08 || code[31:24] !== 8'h5A) begin
      failures++; $display("FAIL bp_refill got=%h/%h exp=08/5a", ov, code[31:24]);
    end
    valid = 1'b0;
    tick();
  endtask

  task automatic test_rr;
    rdy = '1;
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 3'd0, 8'(i));
      @(negedge clk);
      checks++;
      if (ready_o !== 1'b1 || ptr !== 3'((i - 1) % 8)) begin
        failures++;
        $display("FAIL rr_beat%0d got=%b/%0d exp=1/%0d", i, ready_o, ptr, (i - 1) % 8);
      end
      exp_q[(i - 1) % 8].push_back(8'(i));
      tick();
    end
    valid = 1'b0;
    checks++;
    if (ptr !== 3'd2) begin failures++; $display("FAIL rr_ptr_end got=%0d exp=2", ptr); end
    rdy = 8'hFB;
    for (int j = 0; j < 8; j++) begin
      drive(1'b1, 3'd0, 8'(32 + j));
      @(negedge clk);
      checks++;
      if (ready_o !== 1'b1) begin failures++; $display("FAIL rr_fill%0d got=%b exp=1", j, ready_o); end
      exp_q[(2 + j) % 8].push_back(8'(32 + j));
      tick();
    end
    drive(1'b1, 3'd0, 8'h30);
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b0 || ptr !== 3'd2) begin
      failures++; $display("FAIL rr_stall got=%b/%0d exp=0/2", ready_o, ptr);
    end
    tick();
    checks++;
    if (ptr !== 3'd2 || ov[2] !== 1'b1 || code[23:16] !== 8'h20) begin
      failures++; $display("FAIL rr_hold got=%0d/%b/%h exp=2/1/20", ptr, ov[2], code[23:16]);
    end
    rdy = '1;
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b1) begin failures++; $display("FAIL rr_release got=%b exp=1", ready_o); end
    exp_q[2].push_back(8'h30);
    tick();
    valid = 1'b0;
    checks++;
    if (ptr !== 3'd3) begin failures++; $display("FAIL rr_ptr_adv got=%0d exp=3", ptr); end
    tick();
  endtask

  task automatic test_mode_switch;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd0, 8'(65 + i));
      exp_q[i].push_back(8'(65 + i));
      tick();
    end
    checks++;
    if (ptr !== 3'd3) begin failures++; $display("FAIL ms_ptr3 got=%0d exp=3", ptr); end
    drive(1'b0, 3'd6, 8'h46);
    exp_q[6].push_back(8'h46);
    tick();
    checks++;
    if (ptr !== 3'd3 || ov !== 8'h40) begin
      failures++; $display("FAIL ms_addr got=%0d/%h exp=3/40", ptr, ov);
    end
    drive(1'b1, 3'd0, 8'h47);
    exp_q[3].push_back(8'h47);
    tick();
    checks++;
    if (ov !== 8'h08 || code[31:24] !== 8'h47 || ptr !== 3'd4) begin
      failures++; $display("FAIL ms_rr got=%h/%h/%0d exp=08/47/4", ov, code[31:24], ptr);
    end
    valid = 1'b0;
    tick();
  endtask

  task automatic test_drop;
    sel5 = 3'd6; a5 = 8'hEE; valid5 = 1'b1;
    @(negedge clk);
    checks++;
    if (ready5_o !== 1'b1) begin failures++; $display("FAIL drop_ready got=%b exp=1", ready5_o); end
    tick();
    valid5 = 1'b0;
    checks++;
    if (ov5 !== 5'h00 || err5 !== 1'b1 || cnt5 !== 8'd1) begin
      failures++; $display("FAIL drop_one got=%h/%b/%0d exp=00/1/1", ov5, err5, cnt5);
    end
    tick();
    checks++;
    if (err5 !== 1'b0 || cnt5 !== 8'd1) begin
      failures++; $display("FAIL drop_pulse got=%b/%0d exp=0/1", err5, cnt5);
    end
    sel5 = 3'd5; valid5 = 1'b1;
    tick();
    valid5 = 1'b0;
    checks++;
    if (ov5 !== 5'h00 || cnt5 !== 8'd2) begin
      failures++; $display("FAIL drop_edge got=%h/%0d exp=00/2", ov5, cnt5);
    end
    sel5 = 3'd4; a5 = 8'h99; valid5 = 1'b1;
    tick();
    valid5 = 1'b0;
    checks++;
    if (ov5 !== 5'h10 || code5[39:32] !== 8'h99 || err5 !== 1'b0 || cnt5 !== 8'd2) begin
      failures++;
      $display("FAIL inrange5 got=%h/%h/%b/%0d exp=10/99/0/2", ov5, code5[39:32], err5, cnt5);
    end
    sel5 = 3'd7; valid5 = 1'b1;
    repeat (300) tick();
    valid5 = 1'b0;
    checks++;
    if (cnt5 !== 8'd255 || err5 !== 1'b1) begin
      failures++; $display("FAIL drop_sat got=%0d/%b exp=255/1", cnt5, err5);
    end
    tick();
    checks++;
    if (cnt5 !== 8'd255 || err5 !== 1'b0) begin
      failures++; $display("FAIL drop_hold got=%0d/%b exp=255/0", cnt5, err5);
    end
  endtask

  initial begin
    test_reset();
    test_addr();
    test_backpressure();
    test_rr();
    test_mode_switch();
    test_drop();
    tick();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (exp_q[k].size() != 0) begin
        failures++;
        $display("FAIL sb_left_ch%0d got=%0d exp=0", k, exp_q[k].size());
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
